pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage_pkg.sv | 26 ++
 rtl/pipe_skid_stage_sat_counter.sv | 32 +++
 rtl/pipe_skid_stage.sv | 103 ++++++++++
 tb/tb_pipe_skid_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_stage_pkg.sv
// Shared widths, default payload width and state encoding for the pipeline skid stage.
// Also provides the MEM/WB payload packing helper.
package pipe_skid_stage_pkg;

  localparam int WORD_LEN          = 32;
  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int DATA_W_DEF        = 2 + REG_FILE_ADDR_LEN + 2 * WORD_LEN;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  // MSB-first packing: {WB_EN, MEM_R_EN, dest, ALURes, memReadVal}.
  function automatic logic [DATA_W_DEF-1:0] pack_mem_wb(
    input logic                         wb_en,
    input logic                         mem_r_en,
    input logic [REG_FILE_ADDR_LEN-1:0] dest,
    input logic [WORD_LEN-1:0]          alu_res,
    input logic [WORD_LEN-1:0]          mem_read_val
  );
    return {wb_en, mem_r_en, dest, alu_res, mem_read_val};
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter: advances by one on each edge with inc=1, sticks at all-ones.
// Cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with optional 2-entry skid buffer, flush and
// a saturating stall counter.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;
  logic              consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  // Without the skid entry the stage can only take a payload when its single
  // register frees up in the same cycle, so ready must see out_ready directly.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (SKID != 0) begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (accept) begin
        main_d  = in_data;
        state_d = ST_ONE;
      end else if (consume) begin
        state_d = ST_EMPTY;
      end
    end
    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: three instances (default, CNT_W=4, SKID=0) on shared
// stimulus, checked every cycle against a FIFO-occupancy model plus literal expectations.
module tb_pipe_skid_stage;
  import pipe_skid_stage_pkg::*;

  localparam int DW = DATA_W_DEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic flush = 1'b0;

  logic [2:0] ov, ir;
  logic [2:0][DW-1:0] od;
  logic [15:0] sc0, sc2;
  logic [3:0]  sc1;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .SKID(1), .CNT_W(16)) dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .flush(flush), .stall_cnt(sc0));

  pipe_skid_stage #(.DATA_W(DW), .SKID(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .flush(flush), .stall_cnt(sc1));

  pipe_skid_stage #(.DATA_W(DW), .SKID(0), .CNT_W(16)) dut_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .flush(flush), .stall_cnt(sc2));

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is a FIFO of capacity 2 (skid) or 1 (plain register).
  int unsigned    cnt_m   [3];
  int unsigned    stall_m [3];
  logic [DW-1:0]  e0_m    [3];
  logic [DW-1:0]  e1_m    [3];
  logic [DW-1:0]  last_m  [3];

  function automatic bit m_ready(int k);
    if (k == 2) return (cnt_m[k] == 0) || out_ready;
    return cnt_m[k] < 2;
  endfunction

  function automatic int unsigned m_max(int k);
    return (k == 1) ? 15 : 65535;
  endfunction

  always @(posedge clk) begin
    bit acc, con;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        cnt_m[k] = 0; stall_m[k] = 0;
        e0_m[k] = '0; e1_m[k] = '0; last_m[k] = '0;
      end else begin
        acc = in_valid && m_ready(k);
        con = (cnt_m[k] != 0) && out_ready;
        if (cnt_m[k] != 0 && !out_ready && stall_m[k] < m_max(k)) stall_m[k]++;
        if (con) begin
          e0_m[k] = e1_m[k];
          cnt_m[k]--;
        end
        if (flush) cnt_m[k] = 0;
        else if (acc) begin
          if (cnt_m[k] == 0) e0_m[k] = in_data;
          else e1_m[k] = in_data;
          cnt_m[k]++;
        end
        if (cnt_m[k] != 0) last_m[k] = e0_m[k];
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] sck;
    if (checking) begin
      for (int k = 0; k < 3; k++) begin
        sck = (k == 0) ? sc0 : (k == 1) ? {12'b0, sc1} : sc2;
        check($sformatf("model_out_valid[%0d]", k), DW'(ov[k]), DW'(cnt_m[k] != 0));
        check($sformatf("model_in_ready[%0d]", k), DW'(ir[k]), DW'(m_ready(k)));
        check($sformatf("model_out_data[%0d]", k), od[k], last_m[k]);
        check($sformatf("model_stall_cnt[%0d]", k), DW'(sck), DW'(stall_m[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] pa, pb, pc;
    pa = pack_mem_wb(1'b1, 1'b0, 5'd3, 32'hAAAA_0001, 32'h1111_2222);
    pb = DW'(71'h0B0B);
    pc = DW'(71'h0C0C);

    // Reset with a payload offered
    rst = 1'b1; in_valid = 1'b1; in_data = DW'(71'h5A);
    tick(); tick();
    check("rst_out_valid", DW'(ov[0]), DW'(0));
    check("rst_out_data", od[0], DW'(0));
    check("rst_stall_cnt", DW'(sc0), DW'(0));
    check("rst_in_ready", DW'(ir[0]), DW'(1));
    rst = 1'b0; checking = 1'b1;

    // Streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
      check($sformatf("stream_data_%0d", i), od[0], DW'(i));
      check($sformatf("stream_ready_%0d", i), DW'(ir[0]), DW'(1));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", DW'(ov[0]), DW'(0));

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = pa;
    tick();
    check("bp_a_out", od[0], pa);
    in_data = pb;
    tick();
    check("bp_full_ready", DW'(ir[0]), DW'(0));
    check("bp_full_data", od[0], pa);
    check("bp_stall_1", DW'(sc0), DW'(1));
    in_data = pc;
    tick();
    check("bp_hold_ready", DW'(ir[0]), DW'(0));
    check("bp_stall_2", DW'(sc0), DW'(2));
    out_ready = 1'b1;
    tick();
    check("bp_b_out", od[0], pb);
    tick();
    check("bp_c_out", od[0], pc);
    in_valid = 1'b0;
    tick();
    check("bp_empty", DW'(ov[0]), DW'(0));
    check("bp_stall_final", DW'(sc0), DW'(2));

    // Flush in FULL with an offer pending
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(71'hD);
    tick();
    in_data = DW'(71'hE);
    tick();
    flush = 1'b1; in_data = DW'(71'hF);
    tick();
    check("flush_full_valid", DW'(ov[0]), DW'(0));
    check("flush_full_ready", DW'(ir[0]), DW'(1));
    check("flush_full_data_kept", od[0], DW'(71'hD));
    check("flush_full_stall", DW'(sc0), DW'(4));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_full_no_f", DW'(ov[0]), DW'(0));

    // Flush in ONE drops a simultaneous accept
    in_valid = 1'b1; in_data = DW'(71'h16);
    tick();
    flush = 1'b1; in_data = DW'(71'h17);
    tick();
    check("flush_one_valid", DW'(ov[0]), DW'(0));
    check("flush_one_data_kept", od[0], DW'(71'h16));
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_one_no_h", DW'(ov[0]), DW'(0));
    check("flush_one_stall", DW'(sc0), DW'(5));

    // Saturation of the 4-bit counter
    in_valid = 1'b1; in_data = DW'(71'h55);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat_cnt4", DW'(sc1), DW'(15));
    check("sat_cnt16", DW'(sc0), DW'(25));
    for (int i = 0; i < 3; i++) tick();
    check("sat_cnt4_hold", DW'(sc1), DW'(15));
    check("sat_cnt16_more", DW'(sc0), DW'(28));
    out_ready = 1'b1;
    tick();
    check("sat_drained", DW'(ov[0]), DW'(0));

    // SKID=0: out_ready 1,0,1 with in_valid held
    in_valid = 1'b1; in_data = DW'(71'h21); out_ready = 1'b1;
    #1;
    check("ns_ready_empty", DW'(ir[2]), DW'(1));
    tick();
    check("ns_p1_out", od[2], DW'(71'h21));
    in_data = DW'(71'h22); out_ready = 1'b0;
    #1;
    check("ns_ready_stalled", DW'(ir[2]), DW'(0));
    tick();
    check("ns_p1_held", od[2], DW'(71'h21));
    out_ready = 1'b1;
    #1;
    check("ns_ready_consume", DW'(ir[2]), DW'(1));
    tick();
    check("ns_p2_out", od[2], DW'(71'h22));
    in_valid = 1'b0;
    tick();
    check("ns_drained", DW'(ov[2]), DW'(0));

    // Reset mid-operation beats flush and held payloads
    out_ready = 1'b0; in_valid = 1'b1; in_data = DW'(71'h31);
    tick();
    in_data = DW'(71'h32);
    tick();
    rst = 1'b1; flush = 1'b1;
    tick();
    check("midrst_valid", DW'(ov[0]), DW'(0));
    check("midrst_data", od[0], DW'(0));
    check("midrst_ready", DW'(ir[0]), DW'(1));
    check("midrst_stall", DW'(sc0), DW'(0));
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
